// File: rtl/inv_factorial.sv
// inv_factorial: iterative search for the largest n with n! <= value, start/done handshake.
// Optional INV_FACTORIAL_REMAINDER_EN adds rem = value - n!.
module inv_factorial #(
  parameter int DATA_W = 16,
  parameter int N_W = 4,
  parameter int ACC_W = DATA_W + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] fact,
  output logic              busy,
  output logic              done,
  output logic [N_W-1:0]    n,
  output logic              exact,
  output logic              err
`ifdef INV_FACTORIAL_REMAINDER_EN
  ,
  output logic [DATA_W-1:0] rem
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] val;
  logic [ACC_W-1:0] acc;
  logic [N_W-1:0] k;
  logic hit, over, accept;
  assign hit = acc == ACC_W'(val);
  assign over = acc > ACC_W'(val);
  assign accept = state == IDLE && start;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (start ? (fact == '0 ? DONE : RUN) : IDLE) :
               (state == RUN) ? ((hit || over) ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // acc holds k!; it only grows while still below val, so it never exceeds 9! here
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      val <= '0;
      acc <= '0;
      k <= '0;
      n <= '0;
      exact <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      val <= fact;
      acc <= ACC_W'(1);
      k <= N_W'(1);
      n <= '0;
      exact <= 1'b0;
      err <= fact == '0;
    end else if (state == RUN) begin
      if (hit || over) begin
        n <= hit ? k : k - N_W'(1);
        exact <= hit;
        err <= 1'b0;
      end else begin
        acc <= acc * (ACC_W'(k) + ACC_W'(1));
        k <= k + N_W'(1);
      end
    end
`ifdef INV_FACTORIAL_REMAINDER_EN
  // prev keeps (k-1)! so an overshoot can report val - n!
  logic [DATA_W-1:0] prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= '0;
      rem <= '0;
    end else if (accept) begin
      prev <= '0;
      rem <= '0;
    end else if (state == RUN) begin
      if (hit || over) rem <= hit ? '0 : val - prev;
      else prev <= acc[DATA_W-1:0];
    end
`endif
endmodule
